// File: rtl/modulo_teclado_pkg.sv
// Shared definitions for the keypad front end: FSM states, operator key codes
// and the row/column to key-code map used by the scanner.
package modulo_teclado_pkg;

    typedef enum logic [1:0] {
        ESCANEO       = 2'd0,
        ANTIRREBOTE   = 2'd1,
        PULSADO       = 2'd2,
        ESPERA_SOLTAR = 2'd3
    } estado_t;

    localparam logic [3:0] TECLA_SUMA   = 4'hA;
    localparam logic [3:0] TECLA_RESTA  = 4'hB;
    localparam logic [3:0] TECLA_MULT   = 4'hC;
    localparam logic [3:0] TECLA_DIV    = 4'hD;
    localparam logic [3:0] TECLA_IGUAL  = 4'hE;
    localparam logic [3:0] TECLA_BORRAR = 4'hF;

    // With several rows low the lowest-index row wins.
    function automatic logic [3:0] codigo_tecla(input logic [3:0] fila_cap,
                                                input logic [1:0] col);
        logic [1:0] fila;
        logic [3:0] cod;
        fila = 2'd3;
        for (int i = 3; i >= 0; i--) begin
            if (!fila_cap[i]) fila = 2'(i);
        end
        case ({fila, col})
            4'b00_00: cod = 4'h1;
            4'b00_01: cod = 4'h2;
            4'b00_10: cod = 4'h3;
            4'b00_11: cod = TECLA_SUMA;
            4'b01_00: cod = 4'h4;
            4'b01_01: cod = 4'h5;
            4'b01_10: cod = 4'h6;
            4'b01_11: cod = TECLA_RESTA;
            4'b10_00: cod = 4'h7;
            4'b10_01: cod = 4'h8;
            4'b10_10: cod = 4'h9;
            4'b10_11: cod = TECLA_MULT;
            4'b11_00: cod = TECLA_BORRAR;
            4'b11_01: cod = 4'h0;
            4'b11_10: cod = TECLA_IGUAL;
            default:  cod = TECLA_DIV;
        endcase
        return cod;
    endfunction

endpackage

// File: rtl/modulo_teclado_sincronizador.sv
// Two-flop synchronizer for asynchronous level inputs, with a configurable
// reset value so idle (inactive-high) lines do not glitch out of reset.
module sincronizador #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] etapa1;

    always_ff @(posedge clk) begin
        if (reset) begin
            etapa1 <= RESET_VAL;
            q      <= RESET_VAL;
        end else begin
            etapa1 <= d;
            q      <= etapa1;
        end
    end

endmodule

// File: rtl/modulo_teclado.sv
// 4x4 matrix keypad scanner with press/release debounce; emits a one-cycle
// strobe per accepted key, classified as digit, operator, equals or clear.
module modulo_teclado
    import modulo_teclado_pkg::*;
#(
    parameter int SCAN_DIV   = 1000,
    parameter int DEB_CYCLES = 250000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] fila_n,
    output logic [3:0] col_n,
    output logic [3:0] tecla,
    output logic       numero_en,
    output logic       operando_en,
    output logic       igual_en,
    output logic       borrar_en
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DEB_MAX  = DW'(DEB_CYCLES - 1);

    logic [3:0]    fs;
    estado_t       estado, estado_sig;
    logic [1:0]    col_idx, col_idx_sig;
    logic [SW-1:0] scan_cnt, scan_cnt_sig;
    logic [DW-1:0] deb_cnt, deb_cnt_sig;
    logic [3:0]    fila_cap, fila_cap_sig;
    logic [3:0]    tecla_q, tecla_sig;
    logic          en_pulso;

    sincronizador #(.WIDTH(4), .RESET_VAL(4'hF)) u_sinc (
        .clk   (clk),
        .reset (reset),
        .d     (fila_n),
        .q     (fs)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            estado   <= ESCANEO;
            col_idx  <= 2'd0;
            scan_cnt <= '0;
            deb_cnt  <= '0;
            fila_cap <= 4'hF;
            tecla_q  <= 4'h0;
        end else begin
            estado   <= estado_sig;
            col_idx  <= col_idx_sig;
            scan_cnt <= scan_cnt_sig;
            deb_cnt  <= deb_cnt_sig;
            fila_cap <= fila_cap_sig;
            tecla_q  <= tecla_sig;
        end
    end

    // The column index only moves while scanning, so col_n is frozen for the
    // whole press/debounce/release episode.
    always_comb begin
        estado_sig   = estado;
        col_idx_sig  = col_idx;
        scan_cnt_sig = scan_cnt;
        deb_cnt_sig  = deb_cnt;
        fila_cap_sig = fila_cap;
        tecla_sig    = tecla_q;
        case (estado)
            ESCANEO: begin
                if (fs != 4'hF) begin
                    fila_cap_sig = fs;
                    deb_cnt_sig  = '0;
                    scan_cnt_sig = '0;
                    estado_sig   = ANTIRREBOTE;
                end else if (scan_cnt == SCAN_MAX) begin
                    scan_cnt_sig = '0;
                    col_idx_sig  = col_idx + 2'd1;
                end else begin
                    scan_cnt_sig = scan_cnt + SW'(1);
                end
            end
            ANTIRREBOTE: begin
                if (fs != fila_cap) begin
                    deb_cnt_sig = '0;
                    estado_sig  = ESCANEO;
                end else if (deb_cnt == DEB_MAX) begin
                    deb_cnt_sig = '0;
                    tecla_sig   = codigo_tecla(fila_cap, col_idx);
                    estado_sig  = PULSADO;
                end else begin
                    deb_cnt_sig = deb_cnt + DW'(1);
                end
            end
            PULSADO: begin
                deb_cnt_sig = '0;
                estado_sig  = ESPERA_SOLTAR;
            end
            ESPERA_SOLTAR: begin
                if (fs != 4'hF) begin
                    deb_cnt_sig = '0;
                end else if (deb_cnt == DEB_MAX) begin
                    deb_cnt_sig = '0;
                    estado_sig  = ESCANEO;
                end else begin
                    deb_cnt_sig = deb_cnt + DW'(1);
                end
            end
            default: estado_sig = ESCANEO;
        endcase
    end

    // Gating with reset drops a strobe whose PULSADO cycle coincides with reset.
    assign en_pulso = (estado == PULSADO) && !reset;

    always_comb begin
        numero_en   = 1'b0;
        operando_en = 1'b0;
        igual_en    = 1'b0;
        borrar_en   = 1'b0;
        if (en_pulso) begin
            if (tecla_q <= 4'h9)
                numero_en = 1'b1;
            else if (tecla_q <= TECLA_DIV)
                operando_en = 1'b1;
            else if (tecla_q == TECLA_IGUAL)
                igual_en = 1'b1;
            else
                borrar_en = 1'b1;
        end
    end

    assign col_n = ~(4'b0001 << col_idx);
    assign tecla = tecla_q;

endmodule

// File: tb/tb_modulo_teclado.sv
// Bench for modulo_teclado with SCAN_DIV=4, DEB_CYCLES=8: a keypad model drives
// rows from the driven column, a monitor scores every strobe against exp_q.
module tb_modulo_teclado;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 8;
  localparam int LAT      = DEB + 3;  // fila_n low sample -> strobe cycle (2 sync + DEB+1)

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] fila_n;
  logic [3:0] col_n;
  logic [3:0] tecla;
  logic       numero_en, operando_en, igual_en, borrar_en;

  logic [15:0] pulsada = '0;   // bit r*4+c: key at row r, column c held down
  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;
  int n_strobes = 0;
  int last_strobe_cyc = -1;
  logic [5:0] exp_q[$];          // {tipo[1:0], tecla[3:0]}

  typedef struct {
    int         r;
    int         c;
    logic [3:0] tecla;
    logic [1:0] tipo;            // 0 digit, 1 operator, 2 equals, 3 clear
  } vec_t;
  vec_t tabla[16];

  modulo_teclado #(.SCAN_DIV(SCAN_DIV), .DEB_CYCLES(DEB)) dut (
    .clk         (clk),
    .reset       (reset),
    .fila_n      (fila_n),
    .col_n       (col_n),
    .tecla       (tecla),
    .numero_en   (numero_en),
    .operando_en (operando_en),
    .igual_en    (igual_en),
    .borrar_en   (borrar_en)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // keypad: a held key pulls its row low only while its column is driven
  always_comb begin
    fila_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pulsada[r*4+c] && !col_n[c]) fila_n[r] = 1'b0;
  end

  function automatic logic [5:0] modelo(input int r, input int c);
    int code;
    int tipo;
    if (c == 3) code = 10 + r;
    else if (r < 3) code = 3 * r + c + 1;
    else if (c == 0) code = 15;
    else if (c == 1) code = 0;
    else code = 14;
    if (code <= 9) tipo = 0;
    else if (code <= 13) tipo = 1;
    else if (code == 14) tipo = 2;
    else tipo = 3;
    return {2'(tipo), 4'(code)};
  endfunction

  task automatic check(input string nombre, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nombre, act, exp, cyc);
  endtask

  task automatic fail_msg(input string nombre);
    n_checks++;
    $display("FAIL %s: got no event expected event (cycle %0d)", nombre, cyc);
  endtask

  // scoreboard monitor
  always begin : monitor
    int num;
    logic [1:0] tipo;
    @(negedge clk);
    #2;
    num = int'(numero_en) + int'(operando_en) + int'(igual_en) + int'(borrar_en);
    if (num != 0) begin
      n_strobes++;
      last_strobe_cyc = cyc;
      if (num > 1) begin
        n_checks++;
        $display("FAIL strobes_simultaneos: got %0d strobes expected 1", num);
      end
      if (numero_en) tipo = 2'd0;
      else if (operando_en) tipo = 2'd1;
      else if (igual_en) tipo = 2'd2;
      else tipo = 2'd3;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL strobe_inesperado: got tipo=%0d tecla=%h expected none (cycle %0d)", tipo, tecla, cyc);
      end else begin
        check("strobe", {tipo, tecla}, exp_q.pop_front());
      end
    end
  end

  // driver tasks (called at a negedge)
  task automatic esperar_fila(output int m);
    m = -1;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (fila_n != 4'hF) begin
        m = cyc;
        break;
      end
      @(negedge clk);
    end
    if (m < 0) fail_msg("timeout_fila");
  endtask

  task automatic esperar_strobe(input int n0, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      #3;
      if (n_strobes != n0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_msg("timeout_strobe");
  endtask

  task automatic pulsar(input int r, input int c, input int hold, input logic [5:0] exp);
    int m;
    int n0;
    bit ok;
    @(negedge clk);
    exp_q.push_back(exp);
    n0 = n_strobes;
    pulsada[r*4+c] = 1'b1;
    esperar_fila(m);
    esperar_strobe(n0, ok);
    if (ok && m >= 0) begin
      check("latencia", last_strobe_cyc, m + LAT);
      check("col_congelada", col_n, 4'hF ^ (4'b0001 << c));
    end
    repeat (hold) @(negedge clk);
    check("un_strobe", n_strobes, n0 + 1);
    pulsada = '0;
    repeat (30) @(negedge clk);
    #1 check("tecla_mantiene", tecla, exp[3:0]);
  endtask

  initial begin : test
    int m;
    int n0;
    bit ok;
    tabla[0]  = '{0, 0, 4'h1, 2'd0};  tabla[1]  = '{0, 1, 4'h2, 2'd0};
    tabla[2]  = '{0, 2, 4'h3, 2'd0};  tabla[3]  = '{0, 3, 4'hA, 2'd1};
    tabla[4]  = '{1, 0, 4'h4, 2'd0};  tabla[5]  = '{1, 1, 4'h5, 2'd0};
    tabla[6]  = '{1, 2, 4'h6, 2'd0};  tabla[7]  = '{1, 3, 4'hB, 2'd1};
    tabla[8]  = '{2, 0, 4'h7, 2'd0};  tabla[9]  = '{2, 1, 4'h8, 2'd0};
    tabla[10] = '{2, 2, 4'h9, 2'd0};  tabla[11] = '{2, 3, 4'hC, 2'd1};
    tabla[12] = '{3, 0, 4'hF, 2'd3};  tabla[13] = '{3, 1, 4'h0, 2'd0};
    tabla[14] = '{3, 2, 4'hE, 2'd2};  tabla[15] = '{3, 3, 4'hD, 2'd1};

    // reset values
    repeat (3) @(negedge clk);
    #1;
    check("reset_col_n", col_n, 4'b1110);
    check("reset_tecla", tecla, 4'h0);
    check("reset_strobes", {numero_en, operando_en, igual_en, borrar_en}, 4'b0000);

    // idle scan: each column held SCAN_DIV cycles, wrapping 3->0
    @(negedge clk);
    reset = 1'b0;
    for (int j = 0; j < 40; j++) begin
      #1 check("scan_idle", col_n, 4'hF ^ (4'b0001 << ((j / SCAN_DIV) % 4)));
      @(negedge clk);
    end
    check("idle_sin_strobe", n_strobes, 0);

    // key 5 held for a long time: one strobe only
    pulsar(1, 1, 100, {2'd0, 4'h5});

    // key # with 3-cycle bounce before settling
    @(negedge clk);
    exp_q.push_back({2'd2, 4'hE});
    n0 = n_strobes;
    for (int k = 0; k < 20 && col_n != 4'b1011; k++) @(negedge clk);
    for (int b = 0; b < 3; b++) begin
      pulsada[14] = 1'b1;
      repeat (3) @(negedge clk);
      pulsada[14] = 1'b0;
      repeat (3) @(negedge clk);
    end
    check("rebote_sin_strobe", n_strobes, n0);
    pulsada[14] = 1'b1;
    esperar_strobe(n0, ok);
    repeat (20) @(negedge clk);
    check("rebote_un_strobe", n_strobes, n0 + 1);
    pulsada = '0;
    repeat (30) @(negedge clk);

    // A held, then 7 added; both released together
    exp_q.push_back({2'd1, 4'hA});
    n0 = n_strobes;
    pulsada[3] = 1'b1;
    esperar_fila(m);
    esperar_strobe(n0, ok);
    @(negedge clk);
    pulsada[8] = 1'b1;
    repeat (30) @(negedge clk);
    #1 check("segunda_tecla_col", col_n, 4'b0111);
    @(negedge clk);
    pulsada = '0;
    m = cyc;
    repeat (13) @(negedge clk);
    #1 check("soltar_congelada", col_n, 4'b0111);
    @(negedge clk);
    #1 check("soltar_reanuda", col_n, 4'b1110);
    repeat (30) @(negedge clk);
    check("segunda_tecla_ignorada", n_strobes, n0 + 1);

    // rows 0 and 2 low in column 0: row 0 wins
    exp_q.push_back({2'd0, 4'h1});
    n0 = n_strobes;
    pulsada[0] = 1'b1;
    pulsada[8] = 1'b1;
    esperar_strobe(n0, ok);
    repeat (10) @(negedge clk);
    pulsada = '0;
    repeat (30) @(negedge clk);
    check("dos_filas_un_strobe", n_strobes, n0 + 1);

    // whole key map, table driven
    for (int i = 0; i < 16; i++)
      pulsar(tabla[i].r, tabla[i].c, 5, {tabla[i].tipo, tabla[i].tecla});

    // random keys and hold times against the reference model
    for (int i = 0; i < 10; i++) begin
      int r;
      int c;
      r = $urandom_range(0, 3);
      c = $urandom_range(0, 3);
      pulsar(r, c, $urandom_range(0, 40), modelo(r, c));
    end

    // reset landing on the PULSADO cycle of key D
    @(negedge clk);
    n0 = n_strobes;
    pulsada[15] = 1'b1;
    esperar_fila(m);
    if (m >= 0) begin
      repeat (LAT) @(negedge clk);
      reset = 1'b1;
      #1 check("reset_pulsado_strobe", operando_en, 1'b0);
      @(negedge clk);
      #1 check("reset_pulsado_col", col_n, 4'b1110);
      check("reset_pulsado_tecla", tecla, 4'h0);
    end
    pulsada = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("reset_pulsado_sin_strobe", n_strobes, n0);

    check("cola_vacia", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
